// File: rtl/smart_house_pkg.sv
// smart_house_pkg
// Shared types and constants for the multi-zone smart-house controller.
//   climate_state_t : per-zone climate FSM state (IDLE, HEAT, VENT, COOL)
//   CMD_*           : ASCII command codes accepted on the command stream
//   dwell_width()   : counter width able to hold 0..min_dwell
package smart_house_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAT = 2'd1,
    VENT = 2'd2,
    COOL = 2'd3
  } climate_state_t;

  localparam logic [7:0] CMD_MUSIC   = 8'h4D;  // 'M'
  localparam logic [7:0] CMD_LIGHT   = 8'h4C;  // 'L'
  localparam logic [7:0] CMD_CURTAIN = 8'h43;  // 'C'
  localparam logic [7:0] CMD_OFF     = 8'h4F;  // 'O'

  function automatic int dwell_width(input int min_dwell);
    int w;
    w = $clog2(min_dwell + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/zone_climate_fsm.sv
// zone_climate_fsm
// Climate controller for a single zone: latches the zone's temperature
// samples and runs a hysteresis / minimum-dwell state machine whose state
// drives the heater, window and cooler actuators.
// Ports:
//   clock       in   system clock, rising edge
//   reset       in   asynchronous active-high reset
//   temp_valid  in   sample strobe, already qualified for this zone
//   temp_req    in   signed temperature sample (whole degrees C)
//   heater      out  1 while in HEAT
//   window      out  1 while in VENT
//   cooler      out  1 while in COOL
module zone_climate_fsm
  import smart_house_pkg::*;
#(
  parameter int TEMP_W    = 16,
  parameter int LOW_T     = 18,
  parameter int HIGH_T    = 26,
  parameter int VENT_BAND = 3,
  parameter int HYST      = 1,
  parameter int MIN_DWELL = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              temp_valid,
  input  logic [TEMP_W-1:0] temp_req,
  output logic              heater,
  output logic              window,
  output logic              cooler
);

  localparam int DW = dwell_width(MIN_DWELL);

  localparam logic signed [TEMP_W-1:0] MID_T      = TEMP_W'((LOW_T + HIGH_T) / 2);
  localparam logic signed [TEMP_W-1:0] COOL_ON_T  = TEMP_W'(HIGH_T + VENT_BAND);
  localparam logic signed [TEMP_W-1:0] VENT_ON_T  = TEMP_W'(HIGH_T);
  localparam logic signed [TEMP_W-1:0] HEAT_ON_T  = TEMP_W'(LOW_T);
  localparam logic signed [TEMP_W-1:0] HEAT_OFF_T = TEMP_W'(LOW_T + HYST);
  localparam logic signed [TEMP_W-1:0] HOT_OFF_T  = TEMP_W'(HIGH_T - HYST);
  localparam logic [DW-1:0]            DWELL_MAX  = DW'(MIN_DWELL);

  climate_state_t           state_reg, state_next;
  logic [DW-1:0]            dwell_reg;
  logic signed [TEMP_W-1:0] temp_reg;
  logic                     dwell_done;

  assign dwell_done = (dwell_reg == DWELL_MAX);

  // State, dwell counter and latched temperature. The FSM always sees the
  // temperature latched on an earlier edge, which gives the two-cycle
  // strobe-to-actuator latency.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      dwell_reg <= '0;
      temp_reg  <= MID_T;
    end else begin
      state_reg <= state_next;
      if (state_next != state_reg) begin
        dwell_reg <= '0;
      end else if (!dwell_done) begin
        dwell_reg <= dwell_reg + 1'b1;
      end
      if (temp_valid) begin
        temp_reg <= $signed(temp_req);
      end
    end
  end

  // Next-state logic. HEAT and VENT/COOL never reach each other directly;
  // VENT escalates to COOL without waiting for the dwell time.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (temp_reg > COOL_ON_T)      state_next = COOL;
        else if (temp_reg > VENT_ON_T) state_next = VENT;
        else if (temp_reg < HEAT_ON_T) state_next = HEAT;
      end
      HEAT: begin
        if (temp_reg >= HEAT_OFF_T && dwell_done) state_next = IDLE;
      end
      VENT: begin
        if (temp_reg > COOL_ON_T)                     state_next = COOL;
        else if (temp_reg <= HOT_OFF_T && dwell_done) state_next = IDLE;
      end
      COOL: begin
        if (temp_reg <= HOT_OFF_T && dwell_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    heater = 1'b0;
    window = 1'b0;
    cooler = 1'b0;
    case (state_reg)
      HEAT:    heater = 1'b1;
      VENT:    window = 1'b1;
      COOL:    cooler = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/smart_house_zone_ctrl.sv
// smart_house_zone_ctrl
// Multi-zone smart-house controller: decodes the ASCII command stream into
// per-zone music/light/curtain toggles and routes temperature samples to one
// climate FSM per zone.
// Optional build macro NIGHT_MODE_EN adds a 'night' input that forces music
// off and curtains closed on the outputs while keeping the stored toggles.
// Ports:
//   clock, reset            system clock, async active-high reset
//   char_valid/req/zone     command strobe, ASCII code, target zone
//   temp_valid/req/zone     temperature strobe, signed sample, target zone
//   night                   (NIGHT_MODE_EN only) night override
//   music/light/curtain     per-zone toggle outputs
//   window/cooler/heater    per-zone climate actuators
//   cmd_error               one-cycle pulse for a bad code or zone
module smart_house_zone_ctrl
  import smart_house_pkg::*;
#(
  parameter int NUM_ZONES = 4,
  parameter int ZONE_W    = 2,
  parameter int TEMP_W    = 16,
  parameter int LOW_T     = 18,
  parameter int HIGH_T    = 26,
  parameter int VENT_BAND = 3,
  parameter int HYST      = 1,
  parameter int MIN_DWELL = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 char_valid,
  input  logic [7:0]           char_req,
  input  logic [ZONE_W-1:0]    char_zone,
  input  logic                 temp_valid,
  input  logic [TEMP_W-1:0]    temp_req,
  input  logic [ZONE_W-1:0]    temp_zone,
`ifdef NIGHT_MODE_EN
  input  logic                 night,
`endif
  output logic [NUM_ZONES-1:0] music,
  output logic [NUM_ZONES-1:0] light,
  output logic [NUM_ZONES-1:0] curtain,
  output logic [NUM_ZONES-1:0] window,
  output logic [NUM_ZONES-1:0] cooler,
  output logic [NUM_ZONES-1:0] heater,
  output logic                 cmd_error
);

  // One extra bit so NUM_ZONES == 2**ZONE_W still compares correctly.
  localparam logic [ZONE_W:0] ZONE_LIMIT = (ZONE_W + 1)'(NUM_ZONES);

  logic [NUM_ZONES-1:0] music_reg, light_reg, curtain_reg;
  logic                 cmd_error_reg;
  logic                 char_zone_ok, char_code_ok, cmd_accept;

  assign char_zone_ok = ({1'b0, char_zone} < ZONE_LIMIT);
  assign char_code_ok = (char_req == CMD_MUSIC) || (char_req == CMD_LIGHT) ||
                        (char_req == CMD_CURTAIN) || (char_req == CMD_OFF);
  assign cmd_accept   = char_valid && char_zone_ok && char_code_ok;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cmd_error_reg <= 1'b0;
    end else begin
      cmd_error_reg <= char_valid && !(char_zone_ok && char_code_ok);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ZONES; gi++) begin : g_zone
      logic cmd_hit;
      logic temp_hit;

      assign cmd_hit  = cmd_accept && (char_zone == ZONE_W'(gi));
      // gi is always a legal zone, so an address match is enough here and
      // samples for out-of-range zones fall through unclaimed.
      assign temp_hit = temp_valid && (temp_zone == ZONE_W'(gi));

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          music_reg[gi]   <= 1'b0;
          light_reg[gi]   <= 1'b0;
          curtain_reg[gi] <= 1'b0;
        end else if (cmd_hit) begin
          case (char_req)
            CMD_MUSIC:   music_reg[gi]   <= ~music_reg[gi];
            CMD_LIGHT:   light_reg[gi]   <= ~light_reg[gi];
            CMD_CURTAIN: curtain_reg[gi] <= ~curtain_reg[gi];
            CMD_OFF: begin
              music_reg[gi]   <= 1'b0;
              light_reg[gi]   <= 1'b0;
              curtain_reg[gi] <= 1'b0;
            end
            default: ;
          endcase
        end
      end

      zone_climate_fsm #(
        .TEMP_W    (TEMP_W),
        .LOW_T     (LOW_T),
        .HIGH_T    (HIGH_T),
        .VENT_BAND (VENT_BAND),
        .HYST      (HYST),
        .MIN_DWELL (MIN_DWELL)
      ) u_climate (
        .clock      (clock),
        .reset      (reset),
        .temp_valid (temp_hit),
        .temp_req   (temp_req),
        .heater     (heater[gi]),
        .window     (window[gi]),
        .cooler     (cooler[gi])
      );
    end
  endgenerate

  assign light     = light_reg;
  assign cmd_error = cmd_error_reg;

`ifdef NIGHT_MODE_EN
  // Override only the outputs; the stored toggles keep tracking commands.
  assign music   = night ? '0 : music_reg;
  assign curtain = night ? '1 : curtain_reg;
`else
  assign music   = music_reg;
  assign curtain = curtain_reg;
`endif

endmodule

// File: tb/tb_smart_house_zone_ctrl.sv
// tb_smart_house_zone_ctrl
// Directed bench for smart_house_zone_ctrl. A behavioural model of the zone
// rules runs alongside the DUT and is compared every cycle; literal checks
// at key points pin the model. The zone index is widened to 3 bits so that
// out-of-range zones (5, 6) can be addressed.
module tb_smart_house_zone_ctrl;

  localparam int NZ = 4;
  localparam int ZW = 3;
  localparam int TW = 16;

  localparam int S_IDLE = 0;
  localparam int S_HEAT = 1;
  localparam int S_VENT = 2;
  localparam int S_COOL = 3;

  logic          clock;
  logic          reset;
  logic          char_valid;
  logic [7:0]    char_req;
  logic [ZW-1:0] char_zone;
  logic          temp_valid;
  logic [TW-1:0] temp_req;
  logic [ZW-1:0] temp_zone;
  logic [NZ-1:0] music, light, curtain, window, cooler, heater;
  logic          cmd_error;

  int compared;
  int mismatched;
  bit started;

  smart_house_zone_ctrl #(
    .NUM_ZONES (NZ),
    .ZONE_W    (ZW),
    .TEMP_W    (TW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .char_valid (char_valid),
    .char_req   (char_req),
    .char_zone  (char_zone),
    .temp_valid (temp_valid),
    .temp_req   (temp_req),
    .temp_zone  (temp_zone),
    .music      (music),
    .light      (light),
    .curtain    (curtain),
    .window     (window),
    .cooler     (cooler),
    .heater     (heater),
    .cmd_error  (cmd_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_music[NZ], m_light[NZ], m_curtain[NZ];
  int m_err;
  int m_t[NZ], m_st[NZ], m_dw[NZ];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_err = 0;
      for (int z = 0; z < NZ; z++) begin
        m_music[z] = 0; m_light[z] = 0; m_curtain[z] = 0;
        m_t[z] = (18 + 26) / 2; m_st[z] = S_IDLE; m_dw[z] = 0;
      end
    end else begin
      m_err = 0;
      if (char_valid) begin
        if (int'(char_zone) >= NZ) m_err = 1;
        else if (char_req == "M") m_music[char_zone]   = 1 - m_music[char_zone];
        else if (char_req == "L") m_light[char_zone]   = 1 - m_light[char_zone];
        else if (char_req == "C") m_curtain[char_zone] = 1 - m_curtain[char_zone];
        else if (char_req == "O") begin
          m_music[char_zone] = 0; m_light[char_zone] = 0; m_curtain[char_zone] = 0;
        end else m_err = 1;
      end
      for (int z = 0; z < NZ; z++) begin
        int nxt;
        bit done;
        nxt  = m_st[z];
        done = (m_dw[z] == 8);
        case (m_st[z])
          S_IDLE: if (m_t[z] > 29) nxt = S_COOL;
                  else if (m_t[z] > 26) nxt = S_VENT;
                  else if (m_t[z] < 18) nxt = S_HEAT;
          S_HEAT: if (m_t[z] >= 19 && done) nxt = S_IDLE;
          S_VENT: if (m_t[z] > 29) nxt = S_COOL;
                  else if (m_t[z] <= 25 && done) nxt = S_IDLE;
          default: if (m_t[z] <= 25 && done) nxt = S_IDLE;
        endcase
        if (nxt != m_st[z]) m_dw[z] = 0;
        else if (m_dw[z] < 8) m_dw[z] = m_dw[z] + 1;
        m_st[z] = nxt;
        if (temp_valid && int'(temp_zone) == z) m_t[z] = int'($signed(temp_req));
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    if (started && !reset) begin
      logic [NZ-1:0] e_mu, e_li, e_cu, e_wi, e_co, e_he;
      for (int z = 0; z < NZ; z++) begin
        e_mu[z] = (m_music[z] != 0);
        e_li[z] = (m_light[z] != 0);
        e_cu[z] = (m_curtain[z] != 0);
        e_wi[z] = (m_st[z] == S_VENT);
        e_co[z] = (m_st[z] == S_COOL);
        e_he[z] = (m_st[z] == S_HEAT);
      end
      check("model_music",   32'(music),   32'(e_mu));
      check("model_light",   32'(light),   32'(e_li));
      check("model_curtain", 32'(curtain), 32'(e_cu));
      check("model_window",  32'(window),  32'(e_wi));
      check("model_cooler",  32'(cooler),  32'(e_co));
      check("model_heater",  32'(heater),  32'(e_he));
      check("model_cmd_error", 32'(cmd_error), 32'(m_err));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_temp(input int zone, input int value);
    temp_valid = 1'b1;
    temp_zone  = ZW'(zone);
    temp_req   = TW'(value);
    tick();
    temp_valid = 1'b0;
    $display("temp  zone=%0d value=%0d heater=%b window=%b cooler=%b", zone, value, heater, window, cooler);
  endtask

  task automatic send_char(input int zone, input logic [7:0] code);
    char_valid = 1'b1;
    char_zone  = ZW'(zone);
    char_req   = code;
    tick();
    char_valid = 1'b0;
    $display("cmd   zone=%0d code=%s music=%b light=%b curtain=%b err=%b", zone, code, music, light, curtain, cmd_error);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    started    = 1'b0;
    reset      = 1'b1;
    char_valid = 1'b0; char_req = 8'h00; char_zone = '0;
    temp_valid = 1'b0; temp_req = '0;    temp_zone = '0;

    repeat (2) @(posedge clock);
    #1;
    check("reset_outputs", 32'({music, light, curtain, window, cooler, heater, cmd_error}), 32'd0);
    reset   = 1'b0;
    started = 1'b1;

    // Heating with dwell: entry at edge E, 19 latched at E+3, exit at E+9.
    send_temp(1, 15);
    check("heat_not_yet", 32'(heater), 32'h0);
    tick();
    check("heat_on", 32'(heater), 32'h2);
    check("heat_others_zero", 32'({music, light, curtain, window, cooler}), 32'd0);
    send_temp(1, 18);
    tick();
    send_temp(1, 19);
    repeat (5) tick();
    check("heat_dwell_hold", 32'(heater[1]), 32'd1);
    tick();
    check("heat_dwell_exit", 32'(heater[1]), 32'd0);

    // Vent then immediate escalation to cool, then cool-down after dwell.
    send_temp(2, 28);
    tick();
    check("vent_on", 32'(window), 32'h4);
    send_temp(2, 30);
    tick();
    check("vent_to_cool_cooler", 32'(cooler[2]), 32'd1);
    check("vent_to_cool_window", 32'(window[2]), 32'd0);
    send_temp(2, 25);
    repeat (7) tick();
    check("cool_dwell_hold", 32'(cooler[2]), 32'd1);
    tick();
    check("cool_exit", 32'({window[2], cooler[2], heater[2]}), 32'd0);

    // Command path.
    send_char(0, "L");
    check("light_on", 32'(light), 32'h1);
    send_char(0, "L");
    check("light_off", 32'(light), 32'h0);
    send_char(0, "X");
    check("bad_code_err", 32'(cmd_error), 32'd1);
    check("bad_code_nochange", 32'({music, light, curtain}), 32'd0);
    tick();
    check("err_one_cycle", 32'(cmd_error), 32'd0);
    send_char(5, "M");
    check("bad_zone_err", 32'(cmd_error), 32'd1);
    check("bad_zone_nochange", 32'(music), 32'h0);
    send_char(2, "C");
    check("curtain_on", 32'(curtain), 32'h4);

    // Invalid-zone sample is dropped.
    send_temp(6, 50);
    repeat (3) tick();
    check("bad_temp_zone", 32'({window, cooler, heater}), 32'd0);

    // Simultaneous command and sample for zone 3.
    char_valid = 1'b1; char_zone = 3'd3; char_req = "M";
    temp_valid = 1'b1; temp_zone = 3'd3; temp_req = 16'd40;
    tick();
    char_valid = 1'b0; temp_valid = 1'b0;
    check("simul_music", 32'(music), 32'h8);
    check("simul_cooler_early", 32'(cooler[3]), 32'd0);
    tick();
    check("simul_cooler", 32'(cooler[3]), 32'd1);
    send_char(3, "O");
    check("off_clears", 32'({music[3], light[3], curtain[3]}), 32'd0);

    // Negative sample, then asynchronous reset in the middle of HEAT.
    send_temp(1, -5);
    send_char(1, "M");
    send_char(1, "L");
    check("pre_reset_heat", 32'(heater[1]), 32'd1);
    check("pre_reset_music", 32'(music[1]), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_heater", 32'(heater), 32'd0);
    check("async_reset_music", 32'(music), 32'd0);
    check("async_reset_light", 32'(light), 32'd0);
    check("async_reset_all", 32'({curtain, window, cooler, cmd_error}), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (3) tick();
    check("post_reset_idle", 32'({heater, cooler, window}), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/smart_house_zone_ctrl.md
Name: smart_house_zone_ctrl

Overview:
- Multi-zone successor to the single-room smart-house function block.
- Each of NUM_ZONES zones has:
  - music, light and curtain toggles, driven by an 8-bit ASCII command stream;
  - a climate state machine with hysteresis, minimum dwell time and window ventilation, driven by per-zone temperature samples.
- Sits between the house command/sensor front end and the actuator drivers.

Parameters:
NUM_ZONES, 4, number of independent zones
ZONE_W, 2, width of zone index (clog2 of NUM_ZONES, minimum 1)
TEMP_W, 16, signed temperature sample width (whole degrees C)
LOW_T, 18, heating threshold
HIGH_T, 26, ventilation threshold
VENT_BAND, 3, degrees above HIGH_T at which the zone escalates to cooling
HYST, 1, hysteresis band for leaving HEAT/COOL/VENT
MIN_DWELL, 8, minimum cycles spent in a non-IDLE state before returning to IDLE

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
char_valid  in  1  command strobe
char_req  in  8  ASCII command
char_zone  in  ZONE_W  zone addressed by the command
temp_valid  in  1  temperature sample strobe
temp_req  in  TEMP_W  signed temperature sample
temp_zone  in  ZONE_W  zone the sample belongs to
music  out  NUM_ZONES  per-zone music enable
light  out  NUM_ZONES  per-zone light enable
curtain  out  NUM_ZONES  per-zone curtain closed
window  out  NUM_ZONES  per-zone window open (VENT)
cooler  out  NUM_ZONES  per-zone cooler on (COOL)
heater  out  NUM_ZONES  per-zone heater on (HEAT)
cmd_error  out  1  one-cycle pulse on an invalid command or zone

Behaviour:
- Reset: one clock, asynchronous, active-high. All outputs go to 0; every climate FSM goes to IDLE; dwell counters go to 0; latched temperatures go to (LOW_T+HIGH_T)/2. Reset asserted mid-operation aborts everything immediately.
- Command path (registered, 1-cycle latency):
  - 'M' toggles music[char_zone]; 'L' toggles light[char_zone]; 'C' toggles curtain[char_zone].
  - 'O' clears music, light and curtain of that zone.
  - Any other code, or char_zone >= NUM_ZONES: no output change, cmd_error=1 for exactly the next cycle.
- Temperature path:
  - On temp_valid with a valid zone, the sample is latched into that zone's register.
  - Invalid zone: sample dropped silently.
- Climate FSM, one per zone. Uses latched temperature T; evaluated every cycle; comparisons are signed.
  - IDLE: T>HIGH_T+VENT_BAND -> COOL; else T>HIGH_T -> VENT; else T<LOW_T -> HEAT.
  - HEAT: T>=LOW_T+HYST and dwell done -> IDLE.
  - VENT: T>HIGH_T+VENT_BAND -> COOL immediately, ignoring dwell; T<=HIGH_T-HYST and dwell done -> IDLE.
  - COOL: T<=HIGH_T-HYST and dwell done -> IDLE.
  - No direct HEAT<->COOL/VENT transitions; they always pass through IDLE.
  - Dwell counter clears on every state change, increments each cycle and saturates at MIN_DWELL. "Dwell done" means count == MIN_DWELL.
- Outputs are Moore, registered from state: heater=HEAT, window=VENT, cooler=COOL.
  - Sample presented at edge N becomes the latched T at edge N; state changes at edge N+1; outputs are visible after edge N+1 (2-cycle latency from the strobe).
- Simultaneous events:
  - Command and temperature strobes in the same cycle are processed independently.
  - A new sample during dwell updates T but does not restart the dwell counter.

Optional Feature:
NIGHT_MODE_EN:
- Defined: adds input port night (1 bit). While night=1, music outputs read 0 and curtain outputs read 1 for all zones. Stored toggle states are preserved and reappear when night=0. Commands still update the stored state.
- Undefined: no night port; outputs equal stored state directly.

Decomposition:
- smart_house_pkg holds:
  - climate state enum (IDLE, HEAT, VENT, COOL, 2 bits);
  - command constants CMD_MUSIC='M', CMD_LIGHT='L', CMD_CURTAIN='C', CMD_OFF='O'.
- Sub-module zone_climate_fsm is instantiated NUM_ZONES times via generate. It owns the latched temperature, state, dwell counter and heater/window/cooler outputs. The top level contains command decode and the toggle registers.

Test Plan:
- Reset, then temp 15 to zone 1 -> heater[1]=1 two cycles after strobe; all other outputs 0.
- Zone 1 in HEAT, temp 18 -> heater stays 1; temp 19 sent 3 cycles after entry -> heater[1] drops only once dwell reaches 8 cycles, not earlier.
- Temp 28 zone 2 -> window[2]=1; then temp 30 -> cooler[2]=1 and window[2]=0 next state update, no dwell wait; then temp 25 after dwell -> all zone-2 climate outputs 0.
- 'L' zone 0 twice -> light[0] 1 then 0; 'X' -> cmd_error high exactly one cycle, outputs unchanged; zone 5 with NUM_ZONES=4 -> cmd_error pulse.
- 'M' and temp 40 to zone 3 in the same cycle -> music[3]=1 after 1 cycle, cooler[3]=1 after 2 cycles.
- Reset asserted mid-HEAT between clock edges -> heater, music and light go 0 immediately, without waiting for a clock edge.
